// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared class constants and class-field helper for the class split/merge arbiters
package arbitro_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int CLASS_W     = 2;
  localparam int MAX_WORD_W  = 64;

  typedef enum logic [CLASS_W-1:0] {
    CLASS_0 = 2'b00,
    CLASS_1 = 2'b01,
    CLASS_2 = 2'b10,
    CLASS_3 = 2'b11
  } class_e;

  // Class field lives in the top CLASS_W bits of a word of the given width.
  // Callers zero-extend their word to MAX_WORD_W bits.
  function automatic logic [CLASS_W-1:0] class_field(input logic [MAX_WORD_W-1:0] word,
                                                     input int width);
    return word[width-1 -: CLASS_W];
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - four-way round-robin priority search starting at a pointer
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any
);

  // first requester at or after ptr, wrapping modulo 4
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!any && req[ptr + 2'(i)]) begin
        any                = 1'b1;
        gnt_idx            = ptr + 2'(i);
        gnt[ptr + 2'(i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_merge.sv
// rtl/arbitro_rr_merge.sv - round-robin burst merge of four class FIFOs into one downstream FIFO
module arbitro_rr_merge
  import arbitro_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CLASSES*WIDTH-1:0] data_in,
  input  logic [NUM_CLASSES-1:0]       emptyFIFO,
  input  logic                         almost_fullFIFO,
  output logic [NUM_CLASSES-1:0]       pop,
  output logic                         push,
  output logic [WIDTH-1:0]             data_out,
  output logic                         class_err
);

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  logic [1:0]       rr_ptr;
  logic [3:0]       bcnt;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             any;
  logic             pop_en;
  logic [3:0]       cnt_next;
  logic [WIDTH-1:0] word_sel;

  assign req = ~emptyFIFO;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // A pop is only issued when the merge FIFO can still take the word one cycle later.
  assign pop_en = ~reset & ~almost_fullFIFO & any;
  assign pop    = pop_en ? gnt : '0;

  // Skipping to a different channel starts a fresh burst of one.
  assign cnt_next = (gnt_idx == rr_ptr) ? bcnt + 4'd1 : 4'd1;

  // The class FIFO read data arrives one cycle after the pop, so it is steered by the registered grant.
  // Reset kills the in-flight word in the same cycle.
  assign word_sel = data_in[int'(sel_q)*WIDTH +: WIDTH];
  assign push     = valid_q & ~reset;
  assign data_out = push ? word_sel : '0;

  // grant bookkeeping: pointer/burst rotation and the registered grant feeding the output mux
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      bcnt    <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_en;
      if (pop_en) begin
        sel_q <= gnt_idx;
        if (cnt_next == BURST_CNT) begin
          rr_ptr <= gnt_idx + 2'd1;
          bcnt   <= '0;
        end else begin
          rr_ptr <= gnt_idx;
          bcnt   <= cnt_next;
        end
      end
    end
  end

  // sticky flag: a pushed word whose class field disagrees with the channel it came from
  always_ff @(posedge clk) begin
    if (reset) begin
      class_err <= 1'b0;
    end else if (push && (class_field(MAX_WORD_W'(data_out), WIDTH) != sel_q)) begin
      class_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arbitro_rr_merge.sv
// tb/tb_arbitro_rr_merge.sv - randomized model-checked bench for arbitro_rr_merge
module tb_arbitro_rr_merge;

  localparam int WIDTH = 12;
  localparam int BURST = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [4*WIDTH-1:0] data_in = '0;
  logic [3:0]         emptyFIFO = 4'hF;
  logic               almost_fullFIFO = 1'b0;
  logic [3:0]         pop;
  logic               push;
  logic [WIDTH-1:0]   data_out;
  logic               class_err;

  arbitro_rr_merge #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .emptyFIFO       (emptyFIFO),
    .almost_fullFIFO (almost_fullFIFO),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .class_err       (class_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // class FIFO contents and the reference model state
  logic [WIDTH-1:0] q[4][$];
  int               m_ptr = 0;
  int               m_cnt = 0;
  int               m_ch = 0;
  int               exp_g = -1;
  bit               m_pend = 1'b0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_word = '0;

  logic [3:0]       exp_pop;
  logic             exp_push;
  logic             exp_err;
  logic [WIDTH-1:0] exp_dout;
  logic [3:0]       obs_pop;
  logic             obs_push;
  logic             obs_err;
  logic [WIDTH-1:0] obs_dout;

  int               grant_log[$];
  logic [WIDTH-1:0] push_log[$];

  function automatic int idx_of(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 9;
    endcase
  endfunction

  // Present FIFO flags, predict this cycle's outputs, then sample the DUT mid-cycle.
  task automatic eval();
    for (int k = 0; k < 4; k++) emptyFIFO[k] = (q[k].size() == 0);
    exp_push = m_pend && !reset;
    exp_dout = exp_push ? m_word : '0;
    exp_err  = m_err;
    exp_g    = -1;
    if (!reset && !almost_fullFIFO)
      for (int i = 0; i < 4; i++)
        if (exp_g < 0 && q[(m_ptr + i) % 4].size() > 0) exp_g = (m_ptr + i) % 4;
    exp_pop = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    #3;
    obs_pop  = pop;
    obs_push = push;
    obs_dout = data_out;
    obs_err  = class_err;
    if (obs_pop != 4'b0000) grant_log.push_back(idx_of(obs_pop));
    if (obs_push) push_log.push_back(obs_dout);
  endtask

  // Apply the clock edge to the model and to the FIFO read data.
  task automatic advance();
    int c;
    logic [WIDTH-1:0] w;
    bit popped;
    popped = 1'b0;
    w = '0;
    if (exp_push && (m_word[WIDTH-1 -: 2] != 2'(m_ch))) m_err = 1'b1;
    m_pend = 1'b0;
    if (reset) begin
      m_ptr = 0;
      m_cnt = 0;
      m_err = 1'b0;
    end else if (exp_g >= 0) begin
      w = q[exp_g].pop_front();
      popped = 1'b1;
      m_pend = 1'b1;
      m_word = w;
      m_ch   = exp_g;
      c = (exp_g == m_ptr) ? m_cnt + 1 : 1;
      if (c == BURST) begin
        m_ptr = (exp_g + 1) % 4;
        m_cnt = 0;
      end else begin
        m_ptr = exp_g;
        m_cnt = c;
      end
    end
    @(posedge clk);
    #1;
    if (popped) data_in[m_ch*WIDTH +: WIDTH] = w;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    eval();
    advance();
    reset = 1'b0;
    almost_fullFIFO = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      eval();
      n_cmp += 4;
      if (obs_pop !== 4'b0000) begin n_bad++; $display("FAIL reset_pop got %b want 0000", obs_pop); end
      if (obs_push !== 1'b0) begin n_bad++; $display("FAIL reset_push got %b want 0", obs_push); end
      if (obs_dout !== 12'h000) begin n_bad++; $display("FAIL reset_dout got %h want 000", obs_dout); end
      if (obs_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", obs_err); end
      advance();
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      eval();
      n_cmp += 4;
      if (obs_pop !== 4'b0000) begin n_bad++; $display("FAIL idle_pop got %b want 0000", obs_pop); end
      if (obs_push !== 1'b0) begin n_bad++; $display("FAIL idle_push got %b want 0", obs_push); end
      if (obs_dout !== 12'h000) begin n_bad++; $display("FAIL idle_dout got %h want 000", obs_dout); end
      if (obs_err !== 1'b0) begin n_bad++; $display("FAIL idle_err got %b want 0", obs_err); end
      advance();
    end
  endtask

  task automatic test_single_channel();
    logic [WIDTH-1:0] want;
    q[2].push_back(12'h800);
    q[2].push_back(12'h801);
    q[2].push_back(12'h802);
    grant_log.delete();
    push_log.delete();
    for (int c = 0; c < 6; c++) begin
      eval();
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL single_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL single_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL single_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL single_err c=%0d got %b want %b", c, obs_err, exp_err); end
      advance();
    end
    n_cmp += 2;
    if (grant_log.size() !== 3) begin n_bad++; $display("FAIL single_grants got %0d want 3", grant_log.size()); end
    if (push_log.size() !== 3) begin n_bad++; $display("FAIL single_pushes got %0d want 3", push_log.size()); end
    for (int i = 0; i < 3 && i < push_log.size(); i++) begin
      want = 12'h800 + 12'(i);
      n_cmp++;
      if (push_log[i] !== want) begin n_bad++; $display("FAIL single_seq i=%0d got %h want %h", i, push_log[i], want); end
    end
  endtask

  task automatic test_round_robin();
    int want;
    reset_pulse();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 5; j++) q[k].push_back({2'(k), 10'($urandom)});
    grant_log.delete();
    push_log.delete();
    for (int c = 0; c < 24; c++) begin
      eval();
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL rr_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL rr_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL rr_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL rr_err c=%0d got %b want %b", c, obs_err, exp_err); end
      advance();
    end
    n_cmp++;
    if (grant_log.size() < 17) begin n_bad++; $display("FAIL rr_grant_count got %0d want >=17", grant_log.size()); end
    for (int i = 0; i < 17 && i < grant_log.size(); i++) begin
      want = (i < 16) ? i / 4 : 0;
      n_cmp++;
      if (grant_log[i] !== want) begin n_bad++; $display("FAIL rr_order i=%0d got %0d want %0d", i, grant_log[i], want); end
    end
    for (int i = 0; i < push_log.size() && i < grant_log.size(); i++) begin
      n_cmp++;
      if (int'(push_log[i][WIDTH-1 -: 2]) !== grant_log[i]) begin
        n_bad++; $display("FAIL rr_class i=%0d got %0d want %0d", i, push_log[i][WIDTH-1 -: 2], grant_log[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int want[5] = '{1, 1, 1, 1, 2};
    reset_pulse();
    for (int j = 0; j < 6; j++) q[1].push_back({2'd1, 10'(j)});
    for (int j = 0; j < 3; j++) q[2].push_back({2'd2, 10'(j)});
    grant_log.delete();
    push_log.delete();
    for (int c = 0; c < 14; c++) begin
      almost_fullFIFO = (c >= 3 && c <= 5);
      eval();
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL bp_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL bp_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL bp_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL bp_err c=%0d got %b want %b", c, obs_err, exp_err); end
      if (c == 3) begin
        n_cmp += 2;
        if (obs_push !== 1'b1) begin n_bad++; $display("FAIL bp_inflight_push got %b want 1", obs_push); end
        if (obs_pop !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_pop got %b want 0000", obs_pop); end
      end
      advance();
    end
    almost_fullFIFO = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= grant_log.size() || grant_log[i] !== want[i]) begin
        n_bad++; $display("FAIL bp_order i=%0d got %0d want %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, want[i]);
      end
    end
    n_cmp++;
    if (push_log.size() !== 9) begin n_bad++; $display("FAIL bp_push_count got %0d want 9", push_log.size()); end
  endtask

  task automatic test_mismatch();
    reset_pulse();
    q[3].push_back(12'h412);
    for (int c = 0; c < 6; c++) begin
      eval();
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL mm_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL mm_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL mm_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL mm_err c=%0d got %b want %b", c, obs_err, exp_err); end
      advance();
    end
    n_cmp++;
    if (obs_err !== 1'b1) begin n_bad++; $display("FAIL mm_sticky got %b want 1", obs_err); end
    reset = 1'b1;
    eval();
    advance();
    reset = 1'b0;
    eval();
    n_cmp++;
    if (obs_err !== 1'b0) begin n_bad++; $display("FAIL mm_cleared got %b want 0", obs_err); end
    advance();
  endtask

  task automatic test_reset_mid();
    reset_pulse();
    for (int j = 0; j < 3; j++) q[1].push_back({2'd1, 10'(j + 5)});
    eval();
    n_cmp++;
    if (obs_pop !== 4'b0010) begin n_bad++; $display("FAIL rm_first_pop got %b want 0010", obs_pop); end
    advance();
    reset = 1'b1;
    eval();
    n_cmp += 2;
    if (obs_push !== exp_push) begin n_bad++; $display("FAIL rm_drop_push got %b want %b", obs_push, exp_push); end
    if (obs_pop !== 4'b0000) begin n_bad++; $display("FAIL rm_reset_pop got %b want 0000", obs_pop); end
    advance();
    reset = 1'b0;
    q[0].push_back({2'd0, 10'h011});
    q[0].push_back({2'd0, 10'h022});
    for (int c = 0; c < 8; c++) begin
      eval();
      if (c == 0) begin
        n_cmp += 2;
        if (obs_push !== 1'b0) begin n_bad++; $display("FAIL rm_after_push got %b want 0", obs_push); end
        if (obs_pop !== 4'b0001) begin n_bad++; $display("FAIL rm_after_pop got %b want 0001", obs_pop); end
      end
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL rm_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL rm_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL rm_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL rm_err c=%0d got %b want %b", c, obs_err, exp_err); end
      advance();
    end
  endtask

  task automatic test_random();
    int ch;
    reset_pulse();
    for (int c = 0; c < 450; c++) begin
      if (c < 400) begin
        if ($urandom_range(0, 1) == 1) begin
          ch = $urandom_range(0, 3);
          if (q[ch].size() < 8) q[ch].push_back({2'(ch), 10'($urandom)});
        end
        almost_fullFIFO = ($urandom_range(0, 3) == 0);
      end else begin
        almost_fullFIFO = 1'b0;
      end
      eval();
      n_cmp += 4;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL rnd_pop c=%0d got %b want %b", c, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL rnd_push c=%0d got %b want %b", c, obs_push, exp_push); end
      if (obs_dout !== exp_dout) begin n_bad++; $display("FAIL rnd_dout c=%0d got %h want %h", c, obs_dout, exp_dout); end
      if (obs_err !== exp_err) begin n_bad++; $display("FAIL rnd_err c=%0d got %b want %b", c, obs_err, exp_err); end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_back_pressure();
    test_mismatch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
